// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with a registered read port, occupancy flags and
// sticky error flags.
//
// Ports:
//   clk           single clock; all state updates on the rising edge
//   rst           asynchronous active-low reset
//   flush         synchronous clear of contents, pointers and sticky errors
//   wr_en/wr_data write request and write word
//   rd_en         read request; the popped word appears on rd_data one cycle later
//   rd_data       registered read word, held when no read is accepted
//   rd_valid      rd_data holds a word popped in the previous cycle
//   full/empty/almost_full/almost_empty  flags decoded from the registered count
//   count         occupancy 0..DEPTH
//   overflow      sticky: write requested while full
//   underflow     sticky: read requested while empty
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfLvl    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AeLvl    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full_w, empty_w;
    logic wr_accept, rd_accept;

    assign full_w  = (count_q == DepthCnt);
    assign empty_w = (count_q == '0);

    // Flush wins over both requests; full/empty come from the registered count, so a
    // simultaneous read at full does not make room for the write in the same cycle.
    assign wr_accept = wr_en & ~full_w & ~flush;
    assign rd_accept = rd_en & ~empty_w & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wr_en && full_w) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty_w) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; only the pointers and count define which words are live.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AfLvl);
    assign almost_empty = (count_q <= AeLvl);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (8-bit words, depth 8, AF at 6, AE at 1) against a
// queue-based reference model.
module tb_sync_fifo_param;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int total;
    int bad;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] m_rdata;
    logic       m_valid;
    logic       m_ovf;
    logic       m_unf;

    sync_fifo_param #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_rdata = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Drive one cycle of requests, advance the model by the FIFO rules, sample 1 time unit
    // after the edge.
    task automatic do_cycle(input bit w, input logic [7:0] d, input bit r, input bit f);
        bit was_full;
        bit was_empty;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        @(posedge clk);
        was_full  = (mq.size() == 8);
        was_empty = (mq.size() == 0);
        m_valid   = 1'b0;
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (r && !was_empty) begin
                m_rdata = mq.pop_front();
                m_valid = 1'b1;
            end else if (r) begin
                m_unf = 1'b1;
            end
            if (w && !was_full) mq.push_back(d);
            else if (w) m_ovf = 1'b1;
        end
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            bad++; $display("FAIL reset_flags got=%b want=1100", {empty, almost_empty, full, almost_full});
        end
        total++; if ({rd_valid, overflow, underflow} !== 3'b000 || rd_data !== 8'h00) begin
            bad++; $display("FAIL reset_outs got=%b/%h want=000/00", {rd_valid, overflow, underflow}, rd_data);
        end
        @(negedge clk);
        rst = 1'b1;
        // First edge after release must already accept a write
        do_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        total++; if (count !== 4'd1) begin bad++; $display("FAIL first_op_count got=%0d want=1", count); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            total++; if (count !== 4'(i + 1)) begin
                bad++; $display("FAIL fill_count i=%0d got=%0d want=%0d", i, count, i + 1);
            end
            total++; if ({almost_empty, almost_full, full, empty} !==
                         {(i + 1 <= 1), (i + 1 >= 6), (i == 7), 1'b0}) begin
                bad++; $display("FAIL fill_flags i=%0d got=%b", i, {almost_empty, almost_full, full, empty});
            end
        end
        do_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        total++; if (overflow !== 1'b1 || count !== 4'd8) begin
            bad++; $display("FAIL fill_overflow got=%b/%0d want=1/8", overflow, count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (rd_valid !== 1'b1 || rd_data !== 8'(8'h10 + i)) begin
                bad++; $display("FAIL drain_data i=%0d got=%b/%h want=1/%h", i, rd_valid, rd_data, 8'(8'h10 + i));
            end
            total++; if (count !== 4'(7 - i)) begin
                bad++; $display("FAIL drain_count i=%0d got=%0d want=%0d", i, count, 7 - i);
            end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if ({underflow, rd_valid} !== 2'b10 || rd_data !== 8'h17) begin
            bad++; $display("FAIL drain_underflow got=%b/%h want=10/17", {underflow, rd_valid}, rd_data);
        end
    endtask

    task automatic test_wrap();
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (rd_data !== m_rdata || rd_valid !== 1'b1) begin
                bad++; $display("FAIL wrap_pre i=%0d got=%h want=%h", i, rd_data, m_rdata);
            end
        end
        for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b want=1", full); end
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (rd_data !== 8'(8'hA0 + i)) begin
                bad++; $display("FAIL wrap_data i=%0d got=%h want=%h", i, rd_data, 8'(8'hA0 + i));
            end
        end
    endtask

    task automatic test_simultaneous();
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
            total++; if (count !== 4'd4 || rd_valid !== 1'b1 || rd_data !== m_rdata) begin
                bad++; $display("FAIL simul_mid i=%0d got=%0d/%b/%h want=4/1/%h", i, count, rd_valid, rd_data, m_rdata);
            end
        end
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_cycle(1'b1, 8'h99, 1'b1, 1'b0);
        total++; if (count !== 4'd7 || rd_data !== m_rdata || overflow !== 1'b1) begin
            bad++; $display("FAIL simul_full got=%0d/%h/%b want=7/%h/1", count, rd_data, overflow, m_rdata);
        end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        do_cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        total++; if (count !== 4'd1 || rd_valid !== 1'b0 || underflow !== 1'b1) begin
            bad++; $display("FAIL simul_empty got=%0d/%b/%b want=1/0/1", count, rd_valid, underflow);
        end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (rd_data !== 8'h5A) begin bad++; $display("FAIL simul_empty_data got=%h want=5a", rd_data); end
    endtask

    task automatic test_flush();
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (count !== 4'd5 || overflow !== 1'b1) begin
            bad++; $display("FAIL flush_setup got=%0d/%b want=5/1", count, overflow);
        end
        do_cycle(1'b1, 8'h55, 1'b1, 1'b1);
        total++; if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL flush_clear got=%0d/%b/%b/%b want=0/1/0/0", count, empty, overflow, rd_valid);
        end
        total++; if (rd_data !== m_rdata) begin bad++; $display("FAIL flush_hold got=%h want=%h", rd_data, m_rdata); end
        do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_dropped got=%0d want=0", count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_cycle(1'b1, 8'h77, 1'b1, 1'b0);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b want=1", rd_valid); end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        total++; if (count !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            bad++; $display("FAIL arst_outs got=%0d/%b/%h want=0/0/00", count, rd_valid, rd_data);
        end
        total++; if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000) begin
            bad++; $display("FAIL arst_flags got=%b want=110000",
                            {empty, almost_empty, full, almost_full, overflow, underflow});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            do_cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
                     1'($urandom_range(0, 39) == 0));
            total++; if (count !== 4'(mq.size())) begin
                bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, count, mq.size());
            end
            total++; if ({full, empty, almost_full, almost_empty} !==
                         {mq.size() == 8, mq.size() == 0, mq.size() >= 6, mq.size() <= 1}) begin
                bad++; $display("FAIL rnd_flags n=%0d got=%b size=%0d", n, {full, empty, almost_full, almost_empty}, mq.size());
            end
            total++; if (rd_valid !== m_valid || rd_data !== m_rdata) begin
                bad++; $display("FAIL rnd_read n=%0d got=%b/%h want=%b/%h", n, rd_valid, rd_data, m_valid, m_rdata);
            end
            total++; if (overflow !== m_ovf || underflow !== m_unf) begin
                bad++; $display("FAIL rnd_err n=%0d got=%b%b want=%b%b", n, overflow, underflow, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full asserts when count >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-007 SHALL have port flush  input  1  synchronous clear of contents and sticky errors.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write word.
REQ-010 SHALL have port rd_en  input  1  read request.
REQ-011 SHALL have port rd_data  output  DATA_WIDTH  registered read word.
REQ-012 SHALL have port rd_valid  output  1  rd_data holds a word popped in the previous cycle.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-014 SHALL have port count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write iff wr_en=1, full=0, flush=0; the word is stored at wr_ptr, then wr_ptr increments.
REQ-017 SHALL accept a read iff rd_en=1, empty=0, flush=0; the word at rd_ptr is registered into rd_data, then rd_ptr increments.
REQ-018 SHALL have read latency of exactly 1 cycle: rd_valid=1 in the cycle after an accepted read, else 0.
REQ-019 SHALL hold rd_data unchanged when no read is accepted.
REQ-020 SHALL wrap pointers modulo DEPTH (ADDR_WIDTH-bit binary, natural rollover).
REQ-021 SHALL update count: +1 write only, -1 read only, unchanged when both or neither accepted.
REQ-022 SHALL, with simultaneous rd_en/wr_en and 0<count<DEPTH, accept both, count unchanged.
REQ-023 SHALL, when full with rd_en and wr_en, accept only the read (count DEPTH-1 next cycle).
REQ-024 SHALL, when empty with rd_en and wr_en, accept only the write (no fall-through; rd_valid=0).
REQ-025 SHALL derive full=(count==DEPTH), empty=(count==0), almost_full, almost_empty from registered count.
REQ-026 SHALL set overflow when wr_en=1 and full=1 and flush=0; held until flush or reset.
REQ-027 SHALL set underflow when rd_en=1 and empty=1 and flush=0; held until flush or reset.
REQ-028 SHALL, on flush=1, zero both pointers and count, clear overflow/underflow, force rd_valid=0, ignore rd_en/wr_en that cycle; rd_data held.
REQ-029 SHALL not require memory contents to be cleared by reset or flush.
REQ-030 SHALL have no combinational path from inputs to any output.

Reset
REQ-031 SHALL, while rst=0, asynchronously force wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-032 SHALL therefore present after reset empty=1, almost_empty=1, full=0, almost_full=0.
REQ-033 SHALL abandon any in-flight read on reset assertion mid-operation; rd_valid=0 immediately.
REQ-034 SHALL accept the first operation on the first rising clk edge after rst returns to 1.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=1)
REQ-035 SHALL cover fill: 8 writes 0x10..0x17 from reset -> count 1..8, almost_empty drops at count 2, almost_full at 6, full at 8; 9th write -> overflow=1, count stays 8.
REQ-036 SHALL cover drain: 8 reads after fill -> rd_data 0x10..0x17, each with rd_valid one cycle after rd_en; empty at count 0; 9th read -> underflow=1, rd_data stays 0x17, rd_valid=0.
REQ-037 SHALL cover wrap: 5 writes, 5 reads, then 8 writes 0xA0..0xA7 and 8 reads -> data order preserved across pointer rollover.
REQ-038 SHALL cover simultaneous ops: count=4, rd_en=wr_en=1 for 10 cycles -> count stays 4, FIFO order intact; at full both -> only read; at empty both -> only write.
REQ-039 SHALL cover flush: count=5 with overflow=1, flush=1 plus wr_en=1 -> next cycle count=0, empty=1, overflow=0, write dropped.
REQ-040 SHALL cover async reset: rst=0 mid-burst between clk edges -> all outputs reach reset values without a clk edge.
